// File: rtl/water_reminder_ctrl.sv
// rtl/water_reminder_ctrl.sv - hydration reminder FSM with ack sync, quiet hours and drink/missed counters
module water_reminder_ctrl #(
  parameter int ALERT_TIMEOUT_MIN = 5,
  parameter int QUIET_START_HR    = 22,
  parameter int QUIET_END_HR      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] intervalSel,
  input  logic       ack,
  input  logic [3:0] count0,
  input  logic [3:0] count1,
  input  logic [3:0] count2,
  input  logic [3:0] count3,
  input  logic [3:0] count4,
  input  logic [3:0] count5,
  output logic       alertLed,
  output logic       buzzer,
  output logic [1:0] state,
  output logic [3:0] drinks1,
  output logic [3:0] drinks0,
  output logic [3:0] missed
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_ALERT = 2'b10;

  logic [1:0] state_q, state_d;
  logic [5:0] elapsed_q, elapsed_d;
  logic [5:0] alert_min_q, alert_min_d;
  logic [7:0] prev_sec_q;
  logic [2:0] ack_sync_q;
  logic       tone_q, tone_d;
  logic       led_q, led_d;
  logic       buz_q, buz_d;
  logic [3:0] drinks1_q, drinks1_d;
  logic [3:0] drinks0_q, drinks0_d;
  logic [3:0] missed_q, missed_d;

  logic       sec_tick, min_tick, ack_rise, quiet;
  logic [6:0] interval_min;
  logic [7:0] hour;

  // Minute-digit inputs are not needed: minute rollover is seen in the seconds digits
  logic       unused_digits;
  assign unused_digits = ^{count2, count3};

  // Tick, acknowledge-edge and quiet-hour decode from the live inputs
  always_comb begin
    sec_tick = (count0 != prev_sec_q[3:0]);
    min_tick = ({count1, count0} == 8'h00) && (prev_sec_q != 8'h00);
    ack_rise = ack_sync_q[1] & ~ack_sync_q[2];
    hour     = ({4'd0, count5} * 8'd10) + {4'd0, count4};
    quiet    = (hour >= 8'(QUIET_START_HR)) || (hour < 8'(QUIET_END_HR));
    case (intervalSel)
      2'b00:   interval_min = 7'd15;
      2'b01:   interval_min = 7'd30;
      2'b10:   interval_min = 7'd45;
      default: interval_min = 7'd60;
    endcase
  end

  // Next-state logic: enable=0 overrides everything, ack beats a coincident timeout
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    alert_min_d = alert_min_q;
    tone_d      = tone_q;
    drinks1_d   = drinks1_q;
    drinks0_d   = drinks0_q;
    missed_d    = missed_q;
    if (!enable) begin
      state_d     = ST_IDLE;
      elapsed_d   = 6'd0;
      alert_min_d = 6'd0;
      tone_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_WAIT;
          elapsed_d = 6'd0;
        end
        ST_WAIT: begin
          if (min_tick) begin
            if (({1'b0, elapsed_q} + 7'd1) >= interval_min) begin
              state_d     = ST_ALERT;
              elapsed_d   = 6'd0;
              alert_min_d = 6'd0;
              tone_d      = 1'b1;
            end else begin
              elapsed_d = elapsed_q + 6'd1;
            end
          end
        end
        ST_ALERT: begin
          if (sec_tick) tone_d = ~tone_q;
          if (min_tick) alert_min_d = alert_min_q + 6'd1;
          if (ack_rise) begin
            state_d     = ST_WAIT;
            alert_min_d = 6'd0;
            tone_d      = 1'b0;
            if (!(drinks1_q == 4'd9 && drinks0_q == 4'd9)) begin
              if (drinks0_q == 4'd9) begin
                drinks0_d = 4'd0;
                drinks1_d = drinks1_q + 4'd1;
              end else begin
                drinks0_d = drinks0_q + 4'd1;
              end
            end
          end else if (min_tick &&
                       (({1'b0, alert_min_q} + 7'd1) == 7'(ALERT_TIMEOUT_MIN))) begin
            state_d     = ST_WAIT;
            alert_min_d = 6'd0;
            tone_d      = 1'b0;
            if (missed_q != 4'hF) missed_d = missed_q + 4'd1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          elapsed_d   = 6'd0;
          alert_min_d = 6'd0;
          tone_d      = 1'b0;
        end
      endcase
    end
  end

  // Output logic: LED and tone only in ALERT, tone muted during quiet hours
  always_comb begin
    led_d = (state_d == ST_ALERT);
    buz_d = led_d & tone_d & ~quiet;
  end

  // State, counters, synchronizer and previous-digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      elapsed_q   <= 6'd0;
      alert_min_q <= 6'd0;
      prev_sec_q  <= 8'h00;
      ack_sync_q  <= 3'b000;
      tone_q      <= 1'b0;
      led_q       <= 1'b0;
      buz_q       <= 1'b0;
      drinks1_q   <= 4'd0;
      drinks0_q   <= 4'd0;
      missed_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      alert_min_q <= alert_min_d;
      prev_sec_q  <= {count1, count0};
      ack_sync_q  <= {ack_sync_q[1:0], ack};
      tone_q      <= tone_d;
      led_q       <= led_d;
      buz_q       <= buz_d;
      drinks1_q   <= drinks1_d;
      drinks0_q   <= drinks0_d;
      missed_q    <= missed_d;
    end
  end

  assign state    = state_q;
  assign alertLed = led_q;
  assign buzzer   = buz_q;
  assign drinks1  = drinks1_q;
  assign drinks0  = drinks0_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_water_reminder_ctrl.sv
// tb/tb_water_reminder_ctrl.sv - self-checking bench for water_reminder_ctrl
module tb_water_reminder_ctrl;

  logic       clk, reset, enable, ack;
  logic [1:0] intervalSel;
  logic [3:0] count0, count1, count2, count3, count4, count5;
  logic       alertLed, buzzer;
  logic [1:0] state;
  logic [3:0] drinks1, drinks0, missed;
  logic [15:0] dut_vec;

  water_reminder_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .intervalSel(intervalSel), .ack(ack),
    .count0(count0), .count1(count1), .count2(count2), .count3(count3),
    .count4(count4), .count5(count5),
    .alertLed(alertLed), .buzzer(buzzer), .state(state),
    .drinks1(drinks1), .drinks0(drinks0), .missed(missed)
  );

  assign dut_vec = {state, alertLed, buzzer, drinks1, drinks0, missed};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  // Reference model: mode 0 idle, 1 waiting, 2 alerting
  int m_mode, m_elapsed, m_amin, m_drinks, m_missed, m_prev_secs;
  bit m_tone, m_led, m_buz;
  bit m_ack_hist [3];

  function automatic void model_step();
    int secs, hr, interval;
    bit sec_tick, min_tick, ack_rise, quiet;
    if (reset) begin
      m_mode = 0; m_elapsed = 0; m_amin = 0; m_drinks = 0; m_missed = 0;
      m_prev_secs = 0; m_tone = 0; m_led = 0; m_buz = 0;
      m_ack_hist[0] = 0; m_ack_hist[1] = 0; m_ack_hist[2] = 0;
      return;
    end
    secs     = int'(count1) * 16 + int'(count0);
    sec_tick = (int'(count0) != (m_prev_secs % 16));
    min_tick = (secs == 0) && (m_prev_secs != 0);
    ack_rise = m_ack_hist[1] && !m_ack_hist[2];
    m_ack_hist[2] = m_ack_hist[1];
    m_ack_hist[1] = m_ack_hist[0];
    m_ack_hist[0] = ack;
    m_prev_secs = secs;
    hr       = 10 * int'(count5) + int'(count4);
    quiet    = (hr >= 22) || (hr < 6);
    interval = (int'(intervalSel) + 1) * 15;
    if (!enable) begin
      m_mode = 0; m_elapsed = 0; m_amin = 0; m_tone = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_elapsed = 0;
    end else if (m_mode == 1) begin
      if (min_tick) begin
        m_elapsed++;
        if (m_elapsed >= interval) begin
          m_mode = 2; m_elapsed = 0; m_amin = 0; m_tone = 1;
        end
      end
    end else begin
      if (sec_tick) m_tone = !m_tone;
      if (min_tick) m_amin++;
      if (ack_rise) begin
        m_mode = 1; m_amin = 0; m_tone = 0;
        if (m_drinks < 99) m_drinks++;
      end else if (min_tick && m_amin == 5) begin
        m_mode = 1; m_amin = 0; m_tone = 0;
        if (m_missed < 15) m_missed++;
      end
    end
    m_led = (m_mode == 2);
    m_buz = m_led && m_tone && !quiet;
  endfunction

  function automatic logic [15:0] model_vec();
    return {2'(m_mode), m_led, m_buz, 4'(m_drinks / 10), 4'(m_drinks % 10), 4'(m_missed)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_secs(input logic [7:0] v);
    {count1, count0} = v;
  endtask

  task automatic set_hour(input logic [3:0] tens, input logic [3:0] ones);
    count5 = tens;
    count4 = ones;
  endtask

  task automatic rollover();
    set_secs(8'h59); cycle();
    set_secs(8'h00); cycle();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    repeat (3) cycle();
    ack = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; ack = 1'b0; intervalSel = 2'b00;
    set_secs(8'h00); count2 = 4'd0; count3 = 4'd0; set_hour(4'd1, 4'd2);
    cycle(); cycle();
    n_checks++;
    if (dut_vec !== 16'h0000) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 16'h0000);
    end
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_alert_entry();
    enable = 1'b1; intervalSel = 2'b00;
    cycle();
    n_checks++;
    if (state !== 2'b01) begin
      n_errors++; $display("FAIL idle_to_wait: got %b expected %b", state, 2'b01);
    end
    repeat (14) rollover();
    n_checks++;
    if (state !== 2'b01) begin
      n_errors++; $display("FAIL wait_14min: got %b expected %b", state, 2'b01);
    end
    rollover();
    n_checks++;
    if ({state, alertLed, buzzer} !== 4'b1011) begin
      n_errors++; $display("FAIL alert_entry: got %b expected %b", {state, alertLed, buzzer}, 4'b1011);
    end
    count0 = 4'd1; cycle();
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_errors++; $display("FAIL buzz_toggle1: got %b expected %b", buzzer, 1'b0);
    end
    count0 = 4'd2; cycle();
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_errors++; $display("FAIL buzz_toggle2: got %b expected %b", buzzer, 1'b1);
    end
    cycle();
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_errors++; $display("FAIL buzz_hold: got %b expected %b", buzzer, 1'b1);
    end
  endtask

  task automatic test_ack();
    ack = 1'b1;
    cycle();
    n_checks++;
    if (state !== 2'b10) begin
      n_errors++; $display("FAIL ack_edge1: got %b expected %b", state, 2'b10);
    end
    cycle();
    n_checks++;
    if (state !== 2'b10) begin
      n_errors++; $display("FAIL ack_edge2: got %b expected %b", state, 2'b10);
    end
    cycle();
    n_checks++;
    if ({state, drinks1, drinks0, missed} !== {2'b01, 8'h01, 4'd0}) begin
      n_errors++; $display("FAIL ack_edge3: got %h expected %h", {state, drinks1, drinks0, missed}, {2'b01, 8'h01, 4'd0});
    end
    ack = 1'b0;
    repeat (3) cycle();
    ack_pulse();
    n_checks++;
    if ({state, drinks1, drinks0} !== {2'b01, 8'h01}) begin
      n_errors++; $display("FAIL ack_in_wait: got %h expected %h", {state, drinks1, drinks0}, {2'b01, 8'h01});
    end
  endtask

  task automatic test_timeout();
    repeat (15) rollover();
    repeat (4) rollover();
    n_checks++;
    if (state !== 2'b10) begin
      n_errors++; $display("FAIL alert_4min: got %b expected %b", state, 2'b10);
    end
    rollover();
    n_checks++;
    if ({state, missed, drinks0} !== {2'b01, 4'd1, 4'd1}) begin
      n_errors++; $display("FAIL timeout: got %h expected %h", {state, missed, drinks0}, {2'b01, 4'd1, 4'd1});
    end
    repeat (15) rollover();
    repeat (4) rollover();
    set_secs(8'h59); ack = 1'b1;
    cycle(); cycle();
    set_secs(8'h00);
    cycle();
    n_checks++;
    if ({state, drinks1, drinks0, missed} !== {2'b01, 8'h02, 4'd1}) begin
      n_errors++; $display("FAIL ack_beats_timeout: got %h expected %h", {state, drinks1, drinks0, missed}, {2'b01, 8'h02, 4'd1});
    end
    ack = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_quiet_hours();
    logic exp_b;
    repeat (15) rollover();
    set_hour(4'd2, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      count0 = 4'(i); cycle();
      n_checks++;
      if ({alertLed, buzzer} !== 2'b10) begin
        n_errors++; $display("FAIL quiet_sec%0d: got %b expected %b", i, {alertLed, buzzer}, 2'b10);
      end
    end
    set_hour(4'd0, 4'd6);
    cycle();
    for (int i = 5; i <= 8; i++) begin
      count0 = 4'(i); cycle();
      exp_b = (i % 2 == 0);
      n_checks++;
      if ({alertLed, buzzer} !== {1'b1, exp_b}) begin
        n_errors++; $display("FAIL resume_sec%0d: got %b expected %b", i, {alertLed, buzzer}, {1'b1, exp_b});
      end
    end
    set_hour(4'd1, 4'd2);
    ack_pulse();
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_errors++; $display("FAIL quiet_exit: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_drinks_saturate();
    int iter;
    iter = 0;
    while (m_drinks < 99 && iter < 150) begin
      repeat (15) rollover();
      ack_pulse();
      iter++;
    end
    n_checks++;
    if ({drinks1, drinks0} !== 8'h99) begin
      n_errors++; $display("FAIL drinks_reach99: got %h expected %h", {drinks1, drinks0}, 8'h99);
    end
    repeat (15) rollover();
    ack_pulse();
    n_checks++;
    if ({state, drinks1, drinks0} !== {2'b01, 8'h99}) begin
      n_errors++; $display("FAIL drinks_sat: got %h expected %h", {state, drinks1, drinks0}, {2'b01, 8'h99});
    end
    enable = 1'b0;
    cycle();
    n_checks++;
    if (dut_vec !== {2'b00, 2'b00, 8'h99, 4'd1}) begin
      n_errors++; $display("FAIL disable_retain: got %h expected %h", dut_vec, {2'b00, 2'b00, 8'h99, 4'd1});
    end
    reset = 1'b1;
    cycle();
    n_checks++;
    if (dut_vec !== 16'h0000) begin
      n_errors++; $display("FAIL reset_after_sat: got %h expected %h", dut_vec, 16'h0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_live_interval();
    enable = 1'b1; intervalSel = 2'b01;
    cycle();
    repeat (20) rollover();
    n_checks++;
    if (state !== 2'b01) begin
      n_errors++; $display("FAIL wait_20min: got %b expected %b", state, 2'b01);
    end
    intervalSel = 2'b00;
    cycle();
    n_checks++;
    if (state !== 2'b01) begin
      n_errors++; $display("FAIL live_sel_no_tick: got %b expected %b", state, 2'b01);
    end
    rollover();
    n_checks++;
    if ({state, alertLed} !== 3'b101) begin
      n_errors++; $display("FAIL live_sel_alert: got %b expected %b", {state, alertLed}, 3'b101);
    end
    reset = 1'b1; ack = 1'b1;
    set_secs(8'h59); cycle();
    n_checks++;
    if (dut_vec !== 16'h0000) begin
      n_errors++; $display("FAIL reset_mid_alert: got %h expected %h", dut_vec, 16'h0000);
    end
    reset = 1'b0; ack = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int s;
    enable = 1'b1; intervalSel = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 49) == 0) intervalSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ack = ~ack;
      case ($urandom_range(0, 5))
        0, 1:    set_secs(8'h00);
        2:       set_secs(8'($urandom_range(0, 255)));
        default: begin
          s = $urandom_range(0, 59);
          set_secs({4'(s / 10), 4'(s % 10)});
        end
      endcase
      if ($urandom_range(0, 19) == 0) begin
        s = $urandom_range(0, 23);
        set_hour(4'(s / 10), 4'(s % 10));
      end
      cycle();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL random_c%0d: got %h expected %h", c, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_alert_entry();
    test_ack();
    test_timeout();
    test_quiet_hours();
    test_drinks_saturate();
    test_live_interval();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/water_reminder_ctrl.md
WATER_REMINDER_CTRL -- requirements
Module: water_reminder_ctrl

Interface
REQ-001 Parameter ALERT_TIMEOUT_MIN, default 5: minute ticks an unacknowledged alert may last.
REQ-002 Parameter QUIET_START_HR, default 22: first hour (0-23) of buzzer suppression.
REQ-003 Parameter QUIET_END_HR, default 6: first hour after quiet period ends.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; 1 = reminder running.
REQ-007 intervalSel  in  2  reminder interval: 00=15, 01=30, 10=45, 11=60 minutes.
REQ-008 ack  in  1  raw user acknowledge button, asynchronous to clk.
REQ-009 count0..count5  in  4 each  upstream timer BCD digits: sec ones, sec tens, min ones, min tens, hr ones, hr tens.
REQ-010 alertLed  out  1  high while alert is active.
REQ-011 buzzer  out  1  1 Hz on/off alert tone.
REQ-012 state  out  2  current state: 00 IDLE, 01 WAIT, 10 ALERT.
REQ-013 drinks1, drinks0  out  4 each  BCD count of acknowledged reminders (tens, ones).
REQ-014 missed  out  4  binary count of timed-out alerts.

Function
REQ-015 secTick shall be high in any cycle where count0 differs from its value registered on the previous edge.
REQ-016 minTick shall be high in any cycle where {count1,count0} == 00 and its registered previous value was not 00.
REQ-017 ack shall pass through a 2-flop synchronizer, then a third flop for edge detection. ackRise = sync2 & ~sync3.
REQ-018 State changes from an ack shall take effect on the 3rd rising edge, counting the edge that first samples ack high as the 1st.
REQ-019 IDLE: if enable=1, go to WAIT next edge and clear elapsedMin.
REQ-020 WAIT: on minTick, elapsedMin (6-bit) increments.
REQ-021 WAIT: if minTick and elapsedMin+1 >= selected interval, go to ALERT, clear elapsedMin, and set buzzer to 1.
REQ-022 intervalSel is evaluated live. A change to an interval at or below elapsed time triggers ALERT at the next minTick.
REQ-023 ALERT: alertLed=1. The buzzer toggles on each secTick. On minTick, alertMin increments.
REQ-024 ALERT with ackRise: go to WAIT, increment the drinks BCD pair (ones wraps 9->0 with a carry to tens), saturate at 99, clear alertMin.
REQ-025 ALERT with minTick and alertMin+1 == ALERT_TIMEOUT_MIN: go to WAIT, increment missed (saturates at 15), clear alertMin.
REQ-026 If ackRise and the timeout occur in the same cycle, ack shall win: drinks increments and missed is unchanged.
REQ-027 ackRise in IDLE or WAIT shall be ignored and shall not affect the counters.
REQ-028 Quiet hours: hour = 10*count5 + count4. If hour >= QUIET_START_HR or hour < QUIET_END_HR, buzzer shall be forced 0. alertLed and the state machine are unaffected.
REQ-029 enable=0 in any state shall force IDLE on the next edge, clear elapsedMin and alertMin, and force alertLed=0 and buzzer=0. drinks and missed are retained.
REQ-030 All outputs shall be registered. alertLed and buzzer are 0 in every state other than ALERT.
REQ-031 Digit inputs are assumed valid BCD. Non-BCD values shall not cause illegal states; the state encoding 11 shall recover to IDLE.

Reset
REQ-032 reset=1 shall, on the next edge, set state=IDLE and clear elapsedMin, alertMin, drinks1, drinks0, missed, alertLed, buzzer, all synchronizer flops, and the previous-digit registers (the previous seconds value resets to 00).
REQ-033 reset shall take priority over enable, ack and ticks, including mid-ALERT.

Verification
REQ-034 Case 1: reset, enable=1, intervalSel=00, drive 15 minute rollovers at hour 12 -> state=10, alertLed=1, buzzer=1, then buzzer toggles on each second change.
REQ-035 Case 2: in ALERT, pulse ack for 3 cycles -> state=01 on the 3rd edge, drinks=01, missed=0; a second ack in WAIT leaves drinks=01.
REQ-036 Case 3: in ALERT, apply 5 minute rollovers with no ack -> state=01, missed=1. Repeat with ackRise coincident with the 5th rollover -> drinks increments and missed is unchanged.
REQ-037 Case 4: hour digits 2,3 (23:xx) while in ALERT -> alertLed=1, buzzer stays 0. At hour 06 the buzzer resumes toggling.
REQ-038 Case 5: drinks preset to 99 via 99 acks -> a further ack keeps drinks1=9, drinks0=9. Then enable=0 -> state=00 with counts retained. Then reset -> all outputs 0.
REQ-039 Case 6: in WAIT with elapsedMin=20, change intervalSel from 01 to 00 -> ALERT at the next minute rollover.
